tdm_demux4: RTL and testbench

Four-channel time-division demultiplexer for the combinational library's serial links. It sits at the receiving end of a stream built by a 4:1 mux stepping its select 00→01→10→11. The block tracks the active slot internally and steers each incoming sample to its channel as a registered, one-hot-strobed output. It also reassembles complete frames into a parallel word with a one-cycle valid pulse.

---
 rtl/tdm_demux4.sv | 73 +++++++
 tb/tb_tdm_demux4.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux4.sv
// Four-slot TDM demultiplexer: steers each accepted sample to its channel strobe
// and reassembles four consecutive slots into a parallel frame word.
module tdm_demux4 #(
    parameter int W = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [W-1:0]   din,
    input  logic           din_valid,
    input  logic           sof,
    output logic [1:0]     slot,
    output logic [W-1:0]   ch_data,
    output logic [3:0]     ch_strobe,
    output logic [4*W-1:0] frame,
    output logic           frame_valid,
    output logic           frame_err
);

    logic [1:0]     eff_slot;
    logic           realign;
    logic           complete;
    logic [W-1:0]   shadow_reg [4];
    logic [4*W-1:0] assembled;

    // sof forces the sample into slot 0; if we were mid-frame that is a misalignment
    assign eff_slot = sof ? 2'd0 : slot;
    assign realign  = din_valid && sof && (slot != 2'd0);
    assign complete = din_valid && (eff_slot == 2'd3);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic lane_hit;
            assign lane_hit = din_valid && (eff_slot == 2'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    shadow_reg[gi] <= '0;
                end else if (lane_hit) begin
                    shadow_reg[gi] <= din;
                end else if (realign) begin
                    shadow_reg[gi] <= '0;
                end
            end

            // the completing sample bypasses the shadow so frame includes it
            assign assembled[gi*W +: W] = lane_hit ? din : shadow_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot        <= 2'd0;
            ch_data     <= '0;
            ch_strobe   <= 4'b0000;
            frame       <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= complete;
            frame_err   <= realign;
            ch_strobe   <= 4'b0000;
            if (din_valid) begin
                slot      <= eff_slot + 2'd1;
                ch_data   <= din;
                ch_strobe <= 4'b0001 << eff_slot;
            end
            if (complete) begin
                frame <= assembled;
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4 with a W=1 and a W=4 instance sharing clk/rst_n.
module tb_tdm_demux4;

    typedef struct packed {
        logic [3:0]  strobe;
        logic [3:0]  data;
        logic [1:0]  slot;
        logic        fv;
        logic        fe;
        logic [15:0] frame;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        din1 = 1'b0, dv1 = 1'b0, sof1 = 1'b0;
    logic [1:0]  slot1;
    logic        ch_data1;
    logic [3:0]  ch_strobe1;
    logic [3:0]  frame1;
    logic        fv1, fe1;

    logic [3:0]  din4 = 4'h0;
    logic        dv4 = 1'b0, sof4 = 1'b0;
    logic [1:0]  slot4;
    logic [3:0]  ch_data4;
    logic [3:0]  ch_strobe4;
    logic [15:0] frame4;
    logic        fv4, fe4;

    exp_t q1[$];
    exp_t q4[$];
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    tdm_demux4 #(.W(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .din(din1), .din_valid(dv1), .sof(sof1),
        .slot(slot1), .ch_data(ch_data1), .ch_strobe(ch_strobe1),
        .frame(frame1), .frame_valid(fv1), .frame_err(fe1)
    );

    tdm_demux4 #(.W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .din(din4), .din_valid(dv4), .sof(sof4),
        .slot(slot4), .ch_data(ch_data4), .ch_strobe(ch_strobe4),
        .frame(frame4), .frame_valid(fv4), .frame_err(fe4)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endtask

    // monitors: pop an expectation whenever a channel strobe appears
    always @(negedge clk) begin
        exp_t e;
        if (ch_strobe1 != 4'b0000) begin
            if (q1.size() == 0) chk("w1_unexpected_strobe", {28'd0, ch_strobe1}, 32'd0);
            else begin
                e = q1.pop_front();
                chk("w1_strobe", {28'd0, ch_strobe1}, {28'd0, e.strobe});
                chk("w1_data", {31'd0, ch_data1}, {31'd0, e.data[0]});
                chk("w1_slot", {30'd0, slot1}, {30'd0, e.slot});
                chk("w1_fv_fe", {30'd0, fv1, fe1}, {30'd0, e.fv, e.fe});
                chk("w1_frame", {28'd0, frame1}, {28'd0, e.frame[3:0]});
                $display("w1 strobe=%b data=%b slot=%0d fv=%b fe=%b frame=%b",
                         ch_strobe1, ch_data1, slot1, fv1, fe1, frame1);
            end
        end else begin
            chk("w1_idle_flags", {30'd0, fv1, fe1}, 32'd0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (ch_strobe4 != 4'b0000) begin
            if (q4.size() == 0) chk("w4_unexpected_strobe", {28'd0, ch_strobe4}, 32'd0);
            else begin
                e = q4.pop_front();
                chk("w4_strobe", {28'd0, ch_strobe4}, {28'd0, e.strobe});
                chk("w4_data", {28'd0, ch_data4}, {28'd0, e.data});
                chk("w4_slot", {30'd0, slot4}, {30'd0, e.slot});
                chk("w4_fv_fe", {30'd0, fv4, fe4}, {30'd0, e.fv, e.fe});
                chk("w4_frame", {16'd0, frame4}, {16'd0, e.frame});
                $display("w4 strobe=%b data=%h slot=%0d fv=%b fe=%b frame=%h",
                         ch_strobe4, ch_data4, slot4, fv4, fe4, frame4);
            end
        end else begin
            chk("w4_idle_flags", {30'd0, fv4, fe4}, 32'd0);
        end
    end

    task automatic send1(input logic d, input logic s, input logic [3:0] es,
                         input logic [1:0] esl, input logic efv, input logic efe,
                         input logic [3:0] ef);
        @(negedge clk);
        din1 = d; dv1 = 1'b1; sof1 = s;
        q1.push_back('{strobe: es, data: {3'd0, d}, slot: esl, fv: efv, fe: efe,
                       frame: {12'd0, ef}});
        @(posedge clk);
        #1 dv1 = 1'b0; sof1 = 1'b0;
    endtask

    task automatic send4(input logic [3:0] d, input logic s, input logic [3:0] es,
                         input logic [1:0] esl, input logic efv, input logic [15:0] ef);
        @(negedge clk);
        din4 = d; dv4 = 1'b1; sof4 = s;
        q4.push_back('{strobe: es, data: d, slot: esl, fv: efv, fe: 1'b0, frame: ef});
        @(posedge clk);
        #1 dv4 = 1'b0; sof4 = 1'b0;
    endtask

    // one idle edge on the W=1 instance; sof may be raised to prove it is ignored
    task automatic idle1(input logic s, input logic [1:0] esl);
        sof1 = s;
        din1 = ~din1;
        @(posedge clk);
        #1;
        chk("w1_gap_slot", {30'd0, slot1}, {30'd0, esl});
        chk("w1_gap_strobe", {28'd0, ch_strobe1}, 32'd0);
        sof1 = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_w1"}, {slot1, ch_data1, ch_strobe1, frame1, fv1, fe1}, 32'd0);
        chk({tag, "_w4"}, {slot4, ch_data4, ch_strobe4, frame4, fv4, fe4}, 32'd0);
    endtask

    initial begin
        // reset held with toggling inputs
        dv1 = 1'b1; dv4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            din1 = ~din1; din4 = din4 + 4'h3; sof1 = i[0];
            #1 chk_zero("reset_hold");
        end
        dv1 = 1'b0; dv4 = 1'b0; sof1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk_zero("post_release");

        // full-rate frame 0,1,0,1
        send1(1'b0, 1'b1, 4'b0001, 2'd1, 1'b0, 1'b0, 4'b0000);
        send1(1'b1, 1'b0, 4'b0010, 2'd2, 1'b0, 1'b0, 4'b0000);
        send1(1'b0, 1'b0, 4'b0100, 2'd3, 1'b0, 1'b0, 4'b0000);
        send1(1'b1, 1'b0, 4'b1000, 2'd0, 1'b1, 1'b0, 4'b1010);

        // gapped frame 1,0,1,0 (a stray sof during one gap)
        send1(1'b1, 1'b0, 4'b0001, 2'd1, 1'b0, 1'b0, 4'b1010);
        idle1(1'b0, 2'd1);
        send1(1'b0, 1'b0, 4'b0010, 2'd2, 1'b0, 1'b0, 4'b1010);
        idle1(1'b1, 2'd2);
        send1(1'b1, 1'b0, 4'b0100, 2'd3, 1'b0, 1'b0, 4'b1010);
        idle1(1'b0, 2'd3);
        send1(1'b0, 1'b0, 4'b1000, 2'd0, 1'b1, 1'b0, 4'b0101);

        // back-to-back frames giving 1010 then 0101
        send1(1'b0, 1'b1, 4'b0001, 2'd1, 1'b0, 1'b0, 4'b0101);
        send1(1'b1, 1'b0, 4'b0010, 2'd2, 1'b0, 1'b0, 4'b0101);
        send1(1'b0, 1'b0, 4'b0100, 2'd3, 1'b0, 1'b0, 4'b0101);
        send1(1'b1, 1'b0, 4'b1000, 2'd0, 1'b1, 1'b0, 4'b1010);
        send1(1'b1, 1'b0, 4'b0001, 2'd1, 1'b0, 1'b0, 4'b1010);
        send1(1'b0, 1'b0, 4'b0010, 2'd2, 1'b0, 1'b0, 4'b1010);
        send1(1'b1, 1'b0, 4'b0100, 2'd3, 1'b0, 1'b0, 4'b1010);
        send1(1'b0, 1'b0, 4'b1000, 2'd0, 1'b1, 1'b0, 4'b0101);

        // misaligned sof after two samples
        send1(1'b1, 1'b1, 4'b0001, 2'd1, 1'b0, 1'b0, 4'b0101);
        send1(1'b0, 1'b0, 4'b0010, 2'd2, 1'b0, 1'b0, 4'b0101);
        send1(1'b1, 1'b1, 4'b0001, 2'd1, 1'b0, 1'b1, 4'b0101);
        send1(1'b0, 1'b0, 4'b0010, 2'd2, 1'b0, 1'b0, 4'b0101);
        send1(1'b1, 1'b0, 4'b0100, 2'd3, 1'b0, 1'b0, 4'b0101);
        send1(1'b1, 1'b0, 4'b1000, 2'd0, 1'b1, 1'b0, 4'b1101);

        // W=4: partial frame then a short asynchronous reset pulse
        send4(4'h5, 1'b1, 4'b0001, 2'd1, 1'b0, 16'h0000);
        send4(4'h6, 1'b0, 4'b0010, 2'd2, 1'b0, 16'h0000);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 chk_zero("async_reset");
        #1 rst_n = 1'b1;
        send4(4'hA, 1'b0, 4'b0001, 2'd1, 1'b0, 16'h0000);
        send4(4'hB, 1'b0, 4'b0010, 2'd2, 1'b0, 16'h0000);
        send4(4'hC, 1'b0, 4'b0100, 2'd3, 1'b0, 16'h0000);
        send4(4'hD, 1'b0, 4'b1000, 2'd0, 1'b1, 16'hDCBA);

        repeat (3) @(posedge clk);
        #1;
        chk("w1_queue_drained", q1.size(), 32'd0);
        chk("w4_queue_drained", q4.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
